// File: rtl/pong_pkg.sv
// Shared definitions for the ping-pong game blocks: play-state codes and
// player encodings used by the match controller and its consumers.
package pong_pkg;

    // Top-level play state; the numeric codes are visible on game_state.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        RALLY     = 3'd2,
        POINT     = 3'd3,
        GAME_END  = 3'd4,
        MATCH_END = 3'd5
    } game_state_t;

    // Player encoding shared by server and last_winner.
    localparam logic PLAYER_P1 = 1'b0;
    localparam logic PLAYER_P2 = 1'b1;

    // Opponent of the given player.
    function automatic logic other_player(input logic player);
        return ~player;
    endfunction

endpackage

// File: rtl/ms_hold_timer.sv
// Loadable millisecond down-counter. A load arms the timer with HOLD_MS;
// each tick_1ms pulse afterwards counts down, and done pulses in the cycle
// that carries the final tick. A tick in the load cycle is not counted.
module ms_hold_timer #(
    parameter int unsigned HOLD_MS = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick_1ms,
    output logic done
);

    localparam int CNT_W = (HOLD_MS < 2) ? 1 : $clog2(HOLD_MS + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_MS);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic             active_reg;

    // Final tick of an armed hold; combinational so the owner can react
    // on the same edge that consumes the last tick.
    assign done = active_reg && tick_1ms && (count_reg == LAST_VAL);

    // Count register: load wins over counting, disarm after the last tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            count_reg  <= LOAD_VAL;
            active_reg <= 1'b1;
        end else if (active_reg && tick_1ms) begin
            count_reg <= count_reg - LAST_VAL;
            if (count_reg == LAST_VAL) begin
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/match_fsm.sv
// Match controller for the ping-pong game: point scores with win-by-margin
// and deuce collapse, multi-game match tracking, serve rotation and timed
// pauses after each point and game. All outputs come straight from flops.
module match_fsm
    import pong_pkg::*;
#(
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned WIN_POINTS   = 5,
    parameter int unsigned WIN_BY       = 2,
    parameter int unsigned GAMES_TO_WIN = 2,
    parameter int unsigned SERVE_SWAP   = 2,
    parameter int unsigned HOLD_MS      = 500,
    localparam int GAMES_W = (GAMES_TO_WIN < 2) ? 1 : $clog2(GAMES_TO_WIN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_1ms,
    input  logic               start,
    input  logic               serve_hit,
    input  logic               p1_goal,
    input  logic               p2_goal,
    output logic [2:0]         game_state,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [GAMES_W-1:0] p1_games,
    output logic [GAMES_W-1:0] p2_games,
    output logic               server,
    output logic               last_winner,
    output logic               ball_enable
);

    localparam logic [SCORE_W-1:0] DEUCE_PTS = SCORE_W'(WIN_POINTS - 1);
    localparam logic [SCORE_W-1:0] WIN_PTS   = SCORE_W'(WIN_POINTS);
    localparam logic [SCORE_W-1:0] LEAD_PTS  = SCORE_W'(WIN_BY);
    localparam logic [GAMES_W-1:0] MATCH_GAMES = GAMES_W'(GAMES_TO_WIN);
    localparam logic [GAMES_W-1:0] ONE_GAME    = GAMES_W'(1);

    // ------------------------------------------------------------------
    // State and per-player registers (index = player code)
    // ------------------------------------------------------------------
    game_state_t        state_reg;
    logic [SCORE_W-1:0] score_reg [2];
    logic [GAMES_W-1:0] games_reg [2];
    logic               server_reg;
    logic               last_winner_reg;
    logic               ball_enable_reg;
    logic               game_won_reg;
    logic               start_prev_reg;

    // ------------------------------------------------------------------
    // Scoring datapath, evaluated on the goal pulses of this cycle
    // ------------------------------------------------------------------
    logic [1:0]         goal_vec;
    logic [1:0]         point_won;
    logic [SCORE_W-1:0] score_inc [2];
    logic [SCORE_W-1:0] score_new [2];
    logic [1:0]         at_deuce_floor;
    logic [1:0]         game_won_vec;
    logic               single_goal;
    logic               both_goals;
    logic               deuce_tie;
    logic               in_deuce;
    logic               game_won;
    logic [SCORE_W:0]   score_total;
    logic               swap_due;

    assign goal_vec    = {p2_goal, p1_goal};
    assign single_goal = ^goal_vec;
    assign both_goals  = &goal_vec;

    // Equal scores at or beyond the deuce floor fold back to the floor so
    // an extended deuce can never overflow the counters.
    assign deuce_tie = (score_inc[0] == score_inc[1]) && at_deuce_floor[0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        assign point_won[gi]      = goal_vec[gi] & ~goal_vec[1-gi];
        assign score_inc[gi]      = score_reg[gi] + SCORE_W'(point_won[gi]);
        assign at_deuce_floor[gi] = (score_inc[gi] >= DEUCE_PTS);
        assign score_new[gi]      = deuce_tie ? DEUCE_PTS : score_inc[gi];
        assign game_won_vec[gi]   = point_won[gi]
                                 && (score_new[gi] >= WIN_PTS)
                                 && (score_new[gi] > score_new[1-gi])
                                 && ((score_new[gi] - score_new[1-gi]) >= LEAD_PTS);
    end

    assign game_won    = |game_won_vec;
    assign in_deuce    = (score_new[0] >= DEUCE_PTS) && (score_new[1] >= DEUCE_PTS);
    assign score_total = {1'b0, score_new[0]} + {1'b0, score_new[1]};
    // Deuce hands over every point; otherwise every SERVE_SWAP points.
    assign swap_due    = in_deuce || ((32'(score_total) % SERVE_SWAP) == 32'd0);

    // ------------------------------------------------------------------
    // Shared hold timer: armed on entry to POINT and to GAME_END
    // ------------------------------------------------------------------
    logic hold_load;
    logic hold_done;
    logic point_to_game_end;

    assign point_to_game_end = (state_reg == POINT) && hold_done && game_won_reg;
    assign hold_load = ((state_reg == RALLY) && single_goal) || point_to_game_end;

    ms_hold_timer #(
        .HOLD_MS (HOLD_MS)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .tick_1ms (tick_1ms),
        .done     (hold_done)
    );

    // ------------------------------------------------------------------
    // Play-state machine with registered outputs
    // ------------------------------------------------------------------
    // Single sequential process owning state, scores, games and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            for (int i = 0; i < 2; i++) begin
                score_reg[i] <= '0;
                games_reg[i] <= '0;
            end
            server_reg      <= PLAYER_P1;
            last_winner_reg <= PLAYER_P1;
            ball_enable_reg <= 1'b0;
            game_won_reg    <= 1'b0;
            start_prev_reg  <= 1'b0;
        end else begin
            start_prev_reg <= start;
            case (state_reg)
                IDLE: begin
                    for (int i = 0; i < 2; i++) begin
                        score_reg[i] <= '0;
                        games_reg[i] <= '0;
                    end
                    server_reg <= PLAYER_P1;
                    if (start) begin
                        state_reg <= SERVE;
                    end
                end

                SERVE: begin
                    // Goals are ignored until the ball is in play.
                    if (serve_hit) begin
                        state_reg       <= RALLY;
                        ball_enable_reg <= 1'b1;
                    end
                end

                RALLY: begin
                    if (both_goals) begin
                        // Simultaneous goals: replay the point, same server.
                        state_reg       <= SERVE;
                        ball_enable_reg <= 1'b0;
                    end else if (single_goal) begin
                        for (int i = 0; i < 2; i++) begin
                            score_reg[i] <= score_new[i];
                        end
                        last_winner_reg <= goal_vec[1];
                        game_won_reg    <= game_won;
                        if (!game_won && swap_due) begin
                            server_reg <= ~server_reg;
                        end
                        state_reg       <= POINT;
                        ball_enable_reg <= 1'b0;
                    end
                end

                POINT: begin
                    if (hold_done) begin
                        if (game_won_reg) begin
                            games_reg[last_winner_reg] <= games_reg[last_winner_reg] + ONE_GAME;
                            state_reg <= GAME_END;
                        end else begin
                            state_reg <= SERVE;
                        end
                    end
                end

                GAME_END: begin
                    if (games_reg[last_winner_reg] == MATCH_GAMES) begin
                        state_reg <= MATCH_END;
                    end else if (hold_done) begin
                        for (int i = 0; i < 2; i++) begin
                            score_reg[i] <= '0;
                        end
                        // The loser of the game serves first in the next one.
                        server_reg <= other_player(last_winner_reg);
                        state_reg  <= SERVE;
                    end
                end

                MATCH_END: begin
                    // Only a fresh rising edge of start begins a new match.
                    if (start && !start_prev_reg) begin
                        for (int i = 0; i < 2; i++) begin
                            score_reg[i] <= '0;
                            games_reg[i] <= '0;
                        end
                        server_reg      <= PLAYER_P1;
                        last_winner_reg <= PLAYER_P1;
                        game_won_reg    <= 1'b0;
                        state_reg       <= SERVE;
                    end
                end

                default: begin
                    state_reg       <= IDLE;
                    ball_enable_reg <= 1'b0;
                end
            endcase
        end
    end

    assign game_state  = state_reg;
    assign p1_score    = score_reg[PLAYER_P1];
    assign p2_score    = score_reg[PLAYER_P2];
    assign p1_games    = games_reg[PLAYER_P1];
    assign p2_games    = games_reg[PLAYER_P2];
    assign server      = server_reg;
    assign last_winner = last_winner_reg;
    assign ball_enable = ball_enable_reg;

endmodule

// File: tb/tb_match_fsm.sv
// Directed bench for match_fsm: a table of per-cycle input/expected-output
// records covering a full three-game match (straight game, deuce game,
// replay), followed by hand-written restart and mid-hold reset sequences.
module tb_match_fsm;
    import pong_pkg::*;

    logic       clk = 1'b0;
    logic       reset, tick_1ms, start, serve_hit, p1_goal, p2_goal;
    logic [2:0] game_state;
    logic [3:0] p1_score, p2_score;
    logic [1:0] p1_games, p2_games;
    logic       server, last_winner, ball_enable;

    int checks = 0;
    int errors = 0;

    match_fsm #(
        .SCORE_W      (4),
        .WIN_POINTS   (5),
        .WIN_BY       (2),
        .GAMES_TO_WIN (2),
        .SERVE_SWAP   (2),
        .HOLD_MS      (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1ms    (tick_1ms),
        .start       (start),
        .serve_hit   (serve_hit),
        .p1_goal     (p1_goal),
        .p2_goal     (p2_goal),
        .game_state  (game_state),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .p1_games    (p1_games),
        .p2_games    (p2_games),
        .server      (server),
        .last_winner (last_winner),
        .ball_enable (ball_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, sh, g1, g2, tk;
        logic [2:0] st;
        logic [3:0] s1, s2;
        logic [1:0] ga1, ga2;
        logic       srv, lw, be;
    } vec_t;

    vec_t q[$];

    // Expected values carried between rows while building the table.
    int   x_s1, x_s2, x_g1, x_g2;
    logic x_srv, x_lw;

    function automatic vec_t mk(input logic rst, input logic st_in, input logic sh,
                                input logic g1, input logic g2, input logic tk,
                                input logic [2:0] st, input int s1, input int s2,
                                input int ga1, input int ga2,
                                input logic srv, input logic lw, input logic be);
        vec_t v;
        v.rst = rst; v.start = st_in; v.sh = sh; v.g1 = g1; v.g2 = g2; v.tk = tk;
        v.st = st; v.s1 = 4'(s1); v.s2 = 4'(s2); v.ga1 = 2'(ga1); v.ga2 = 2'(ga2);
        v.srv = srv; v.lw = lw; v.be = be;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock, and compare all outputs after the edge.
    task automatic apply(input int idx, input vec_t v);
        reset = v.rst; start = v.start; serve_hit = v.sh;
        p1_goal = v.g1; p2_goal = v.g2; tick_1ms = v.tk;
        @(posedge clk);
        #1;
        chk("game_state",  idx, 32'(game_state),  32'(v.st));
        chk("p1_score",    idx, 32'(p1_score),    32'(v.s1));
        chk("p2_score",    idx, 32'(p2_score),    32'(v.s2));
        chk("p1_games",    idx, 32'(p1_games),    32'(v.ga1));
        chk("p2_games",    idx, 32'(p2_games),    32'(v.ga2));
        chk("server",      idx, 32'(server),      32'(v.srv));
        chk("last_winner", idx, 32'(last_winner), 32'(v.lw));
        chk("ball_enable", idx, 32'(ball_enable), 32'(v.be));
        $display("step %0d: st=%0d score=%0d-%0d games=%0d-%0d srv=%0d lw=%0d be=%0d",
                 idx, game_state, p1_score, p2_score, p1_games, p2_games,
                 server, last_winner, ball_enable);
    endtask

    // One full point: serve, goal (with an entry-cycle tick that must not
    // count), then a 3-tick hold with an idle cycle in the middle.
    task automatic add_point(input logic w, input int n1, input int n2,
                             input logic srv_after, input logic won);
        q.push_back(mk(0,1,1,0,0,0, RALLY, x_s1,x_s2,x_g1,x_g2, x_srv,x_lw,1));
        q.push_back(mk(0,1,0,!w,w,1, POINT, n1,n2,x_g1,x_g2, srv_after,w,0));
        x_s1 = n1; x_s2 = n2; x_srv = srv_after; x_lw = w;
        q.push_back(mk(0,1,0,0,0,1, POINT, x_s1,x_s2,x_g1,x_g2, x_srv,x_lw,0));
        q.push_back(mk(0,1,0,0,0,0, POINT, x_s1,x_s2,x_g1,x_g2, x_srv,x_lw,0));
        q.push_back(mk(0,1,0,0,0,1, POINT, x_s1,x_s2,x_g1,x_g2, x_srv,x_lw,0));
        if (won) begin
            if (w) x_g2++; else x_g1++;
            q.push_back(mk(0,1,0,0,0,1, GAME_END, x_s1,x_s2,x_g1,x_g2, x_srv,x_lw,0));
        end else begin
            q.push_back(mk(0,1,0,0,0,1, SERVE, x_s1,x_s2,x_g1,x_g2, x_srv,x_lw,0));
        end
    endtask

    // Game-end hold that is not the last game: 3 ticks, then next game.
    task automatic add_game_hold();
        q.push_back(mk(0,1,0,0,0,1, GAME_END, x_s1,x_s2,x_g1,x_g2, x_srv,x_lw,0));
        q.push_back(mk(0,1,0,0,0,1, GAME_END, x_s1,x_s2,x_g1,x_g2, x_srv,x_lw,0));
        x_s1 = 0; x_s2 = 0; x_srv = !x_lw;
        q.push_back(mk(0,1,0,0,0,1, SERVE, 0,0,x_g1,x_g2, x_srv,x_lw,0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; serve_hit = 1'b0;
        p1_goal = 1'b0; p2_goal = 1'b0; tick_1ms = 1'b0;

        x_s1 = 0; x_s2 = 0; x_g1 = 0; x_g2 = 0; x_srv = 1'b0; x_lw = 1'b0;

        // Reset state.
        q.push_back(mk(1,0,0,0,0,0, IDLE, 0,0,0,0, 0,0,0));
        q.push_back(mk(1,1,1,1,0,1, IDLE, 0,0,0,0, 0,0,0));
        q.push_back(mk(0,1,0,0,0,0, SERVE, 0,0,0,0, 0,0,0));
        // Goal in SERVE is dropped.
        q.push_back(mk(0,1,0,1,0,0, SERVE, 0,0,0,0, 0,0,0));

        // Game 1: P1 wins 5-0.
        add_point(0, 1,0, 0, 0);
        add_point(0, 2,0, 1, 0);
        add_point(0, 3,0, 1, 0);
        add_point(0, 4,0, 0, 0);
        add_point(0, 5,0, 0, 1);
        add_game_hold();                    // scores 0-0, server = P2

        // Game 2: deuce, P2 wins 6-4 after a 5-5 collapse.
        add_point(0, 1,0, 1, 0);
        add_point(1, 1,1, 0, 0);
        add_point(0, 2,1, 0, 0);
        add_point(1, 2,2, 1, 0);
        add_point(0, 3,2, 1, 0);
        add_point(1, 3,3, 0, 0);
        add_point(0, 4,3, 0, 0);
        add_point(1, 4,4, 1, 0);
        add_point(0, 5,4, 0, 0);
        add_point(1, 4,4, 1, 0);            // 5-5 folds to 4-4
        add_point(1, 4,5, 0, 0);
        add_point(1, 4,6, 0, 1);
        add_game_hold();                    // server = P1

        // Game 3: replay first, then P2 wins 5-0 and the match.
        q.push_back(mk(0,1,1,0,0,0, RALLY, 0,0,x_g1,x_g2, x_srv,x_lw,1));
        q.push_back(mk(0,1,0,1,1,0, SERVE, 0,0,x_g1,x_g2, x_srv,x_lw,0));
        add_point(1, 0,1, 0, 0);
        add_point(1, 0,2, 1, 0);
        add_point(1, 0,3, 1, 0);
        add_point(1, 0,4, 0, 0);
        add_point(1, 0,5, 0, 1);
        q.push_back(mk(0,1,0,0,0,0, MATCH_END, 0,5,1,2, 0,1,0));

        for (int i = 0; i < q.size(); i++) begin
            apply(i, q[i]);
        end

        // start held high across MATCH_END: frozen; goals/ticks ignored.
        apply(1000, mk(0,1,0,0,0,1, MATCH_END, 0,5,1,2, 0,1,0));
        apply(1001, mk(0,1,1,1,0,0, MATCH_END, 0,5,1,2, 0,1,0));
        apply(1002, mk(0,1,0,0,1,1, MATCH_END, 0,5,1,2, 0,1,0));
        // Fresh rising edge restarts with everything cleared.
        apply(1003, mk(0,0,0,0,0,0, MATCH_END, 0,5,1,2, 0,1,0));
        apply(1004, mk(0,1,0,0,0,0, SERVE, 0,0,0,0, 0,0,0));

        // Reset in the middle of a POINT hold wins over all other inputs.
        apply(1005, mk(0,1,1,0,0,0, RALLY, 0,0,0,0, 0,0,1));
        apply(1006, mk(0,1,0,1,0,0, POINT, 1,0,0,0, 0,0,0));
        apply(1007, mk(0,1,0,0,0,1, POINT, 1,0,0,0, 0,0,0));
        apply(1008, mk(1,1,1,0,1,1, IDLE, 0,0,0,0, 0,0,0));
        apply(1009, mk(0,0,0,1,0,1, IDLE, 0,0,0,0, 0,0,0));
        apply(1010, mk(0,1,0,0,0,0, SERVE, 0,0,0,0, 0,0,0));
        apply(1011, mk(0,1,0,1,0,0, SERVE, 0,0,0,0, 0,0,0));
        apply(1012, mk(0,1,1,0,0,0, RALLY, 0,0,0,0, 0,0,1));
        apply(1013, mk(0,1,0,0,1,0, POINT, 0,1,0,0, 0,1,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
